// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the RR/EX boundary.
//   DEF_XLEN, DEF_ALUOP_W : default datapath and ALU-op widths
//   ex_ctrl_t             : control bits carried into EX
//   BUBBLE_CTRL           : control value of an inserted bubble (all zero)
//   ex_state_t            : RR/EX stall FSM states
package pipe_pkg;

    localparam int unsigned DEF_XLEN    = 32;
    localparam int unsigned DEF_ALUOP_W = 4;

    typedef struct packed {
        logic reg_we;
        logic mem_re;   // load flag; published as ctrl_l_ex
        logic mem_we;
        logic branch;
        logic ctrl_r;
    } ex_ctrl_t;

    localparam ex_ctrl_t BUBBLE_CTRL = '0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } ex_state_t;

endpackage

// File: rtl/rr_ex_stage.sv
// RR -> EX pipeline register with load-use stall and branch-flush control.
// Priority per edge: rst > flush_ex > h_lock > normal load.
//   clk, rst (sync, active-high)
//   h_lock      : load-use stall request from the hazard unit
//   flush_ex    : taken branch/jump resolved in EX, kills RR contents
//   *_rr        : fields of the instruction sitting in RR
//   pc_en, if_rr_en, if_rr_flush : combinational upstream controls
//   *_ex        : registered copies of the RR fields (bubble on lock/flush)
//   stall_len   : consecutive stall cycles, saturating at 3
// Optional macro RR_EX_PERF_CNT_EN adds stall_cnt / flush_cnt counters.
module rr_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN    = DEF_XLEN,
    parameter int unsigned ALUOP_W = DEF_ALUOP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               h_lock,
    input  logic               flush_ex,
    input  logic               valid_rr,
    input  logic [XLEN-1:0]    pc_rr,
    input  logic [XLEN-1:0]    rs1_data_rr,
    input  logic [XLEN-1:0]    rs2_data_rr,
    input  logic [XLEN-1:0]    imm_rr,
    input  logic [4:0]         rd_rr,
    input  logic [ALUOP_W-1:0] aluop_rr,
    input  logic               reg_we_rr,
    input  logic               mem_re_rr,
    input  logic               mem_we_rr,
    input  logic               branch_rr,
    input  logic               ctrl_r_rr,
    output logic               pc_en,
    output logic               if_rr_en,
    output logic               if_rr_flush,
    output logic               valid_ex,
    output logic [XLEN-1:0]    pc_ex,
    output logic [XLEN-1:0]    rs1_data_ex,
    output logic [XLEN-1:0]    rs2_data_ex,
    output logic [XLEN-1:0]    imm_ex,
    output logic [4:0]         rd_ex,
    output logic [ALUOP_W-1:0] aluop_ex,
    output logic               reg_we_ex,
    output logic               ctrl_l_ex,
    output logic               mem_we_ex,
    output logic               branch_ex,
    output logic               ctrl_r_ex,
`ifdef RR_EX_PERF_CNT_EN
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt,
`endif
    output logic [1:0]         stall_len
);

    ex_state_t state_q, state_d;
    logic [1:0] len_d;
    ex_ctrl_t  ctrl_q;
    ex_ctrl_t  ctrl_rr;
    logic      bubble;

    // Invalid RR slots never carry live control into EX.
    always_comb begin
        ctrl_rr = BUBBLE_CTRL;
        if (valid_rr) begin
            ctrl_rr.reg_we = reg_we_rr;
            ctrl_rr.mem_re = mem_re_rr;
            ctrl_rr.mem_we = mem_we_rr;
            ctrl_rr.branch = branch_rr;
            ctrl_rr.ctrl_r = ctrl_r_rr;
        end
    end

    // Upstream enables. Reset also drives flush so IF/RR clears with us.
    always_comb begin
        pc_en       = 1'b1;
        if_rr_en    = 1'b1;
        if_rr_flush = 1'b0;
        if (rst || flush_ex) begin
            if_rr_flush = 1'b1;
        end else if (h_lock) begin
            pc_en    = 1'b0;
            if_rr_en = 1'b0;
        end
    end

    assign bubble = flush_ex | h_lock;

    // Next-state / stall-length logic; stall_len only keeps counting while
    // the FSM was already in STALL, so the first locked cycle always reads 1.
    always_comb begin
        state_d = RUN;
        len_d   = 2'd0;
        if (!flush_ex && h_lock) begin
            state_d = STALL;
            if (state_q == STALL)
                len_d = (stall_len == 2'd3) ? 2'd3 : stall_len + 2'd1;
            else
                len_d = 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            stall_len <= 2'd0;
        end else begin
            state_q   <= state_d;
            stall_len <= len_d;
        end
    end

    // EX register. Bubbles clear only valid/rd/control; data fields hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_ex    <= 1'b0;
            pc_ex       <= '0;
            rs1_data_ex <= '0;
            rs2_data_ex <= '0;
            imm_ex      <= '0;
            rd_ex       <= '0;
            aluop_ex    <= '0;
            ctrl_q      <= BUBBLE_CTRL;
        end else if (bubble) begin
            valid_ex <= 1'b0;
            rd_ex    <= '0;
            ctrl_q   <= BUBBLE_CTRL;
        end else begin
            valid_ex    <= valid_rr;
            pc_ex       <= pc_rr;
            rs1_data_ex <= rs1_data_rr;
            rs2_data_ex <= rs2_data_rr;
            imm_ex      <= imm_rr;
            rd_ex       <= rd_rr;
            aluop_ex    <= aluop_rr;
            ctrl_q      <= ctrl_rr;
        end
    end

    assign reg_we_ex = ctrl_q.reg_we;
    assign ctrl_l_ex = ctrl_q.mem_re;
    assign mem_we_ex = ctrl_q.mem_we;
    assign branch_ex = ctrl_q.branch;
    assign ctrl_r_ex = ctrl_q.ctrl_r;

`ifdef RR_EX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (h_lock && !flush_ex)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush_ex)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rr_ex_stage.sv
// Directed self-checking bench for rr_ex_stage. Inputs change 1 ns after
// each rising edge; combinational outputs are checked shortly after that,
// registered outputs after the following edge.
module tb_rr_ex_stage;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ALUOP_W = 4;

    logic               clk = 1'b0;
    logic               rst, h_lock, flush_ex, valid_rr;
    logic [XLEN-1:0]    pc_rr, rs1_data_rr, rs2_data_rr, imm_rr;
    logic [4:0]         rd_rr;
    logic [ALUOP_W-1:0] aluop_rr;
    logic               reg_we_rr, mem_re_rr, mem_we_rr, branch_rr, ctrl_r_rr;
    logic               pc_en, if_rr_en, if_rr_flush, valid_ex;
    logic [XLEN-1:0]    pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
    logic [4:0]         rd_ex;
    logic [ALUOP_W-1:0] aluop_ex;
    logic               reg_we_ex, ctrl_l_ex, mem_we_ex, branch_ex, ctrl_r_ex;
    logic [1:0]         stall_len;
`ifdef RR_EX_PERF_CNT_EN
    logic [31:0]        stall_cnt, flush_cnt;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned n_enter;

    always #5 clk = ~clk;

    rr_ex_stage #(.XLEN(XLEN), .ALUOP_W(ALUOP_W)) dut (
        .clk(clk), .rst(rst), .h_lock(h_lock), .flush_ex(flush_ex),
        .valid_rr(valid_rr), .pc_rr(pc_rr), .rs1_data_rr(rs1_data_rr),
        .rs2_data_rr(rs2_data_rr), .imm_rr(imm_rr), .rd_rr(rd_rr),
        .aluop_rr(aluop_rr), .reg_we_rr(reg_we_rr), .mem_re_rr(mem_re_rr),
        .mem_we_rr(mem_we_rr), .branch_rr(branch_rr), .ctrl_r_rr(ctrl_r_rr),
        .pc_en(pc_en), .if_rr_en(if_rr_en), .if_rr_flush(if_rr_flush),
        .valid_ex(valid_ex), .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex),
        .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex), .rd_ex(rd_ex),
        .aluop_ex(aluop_ex), .reg_we_ex(reg_we_ex), .ctrl_l_ex(ctrl_l_ex),
        .mem_we_ex(mem_we_ex), .branch_ex(branch_ex), .ctrl_r_ex(ctrl_r_ex),
`ifdef RR_EX_PERF_CNT_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .stall_len(stall_len)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs may be changed right after return.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rr(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                          input logic we, input logic ld);
        valid_rr    = v;
        pc_rr       = pc;
        rd_rr       = rd;
        reg_we_rr   = we;
        mem_re_rr   = ld;
        mem_we_rr   = 1'b0;
        branch_rr   = 1'b0;
        ctrl_r_rr   = 1'b0;
        rs1_data_rr = pc ^ 32'hA5A5_0000;
        rs2_data_rr = pc + 32'd1;
        imm_rr      = pc + 32'd2;
        aluop_rr    = 4'd3;
    endtask

    initial begin
        // Reset with random RR inputs
        rst = 1'b1; h_lock = 1'b0; flush_ex = 1'b0;
        valid_rr = 1'b1; pc_rr = $urandom; rs1_data_rr = $urandom;
        rs2_data_rr = $urandom; imm_rr = $urandom; rd_rr = 5'($urandom);
        aluop_rr = 4'($urandom); reg_we_rr = 1'b1; mem_re_rr = 1'b1;
        mem_we_rr = 1'b1; branch_rr = 1'b1; ctrl_r_rr = 1'b1;
        step(); step();
        check("rst_valid", valid_ex, 0);
        check("rst_pc", pc_ex, 0);
        check("rst_rs1", rs1_data_ex, 0);
        check("rst_rd", rd_ex, 0);
        check("rst_ctrl", {reg_we_ex, ctrl_l_ex, mem_we_ex, branch_ex, ctrl_r_ex}, 0);
        check("rst_len", stall_len, 0);
        check("rst_upstream", {pc_en, if_rr_en, if_rr_flush}, 3'b111);

        // Normal transfer
        rst = 1'b0;
        set_rr(1'b1, 32'h100, 5'd5, 1'b1, 1'b1);
        #1;
        check("run_upstream", {pc_en, if_rr_en, if_rr_flush}, 3'b110);
        step();
        check("norm_pc", pc_ex, 32'h100);
        check("norm_rd", rd_ex, 5);
        check("norm_we", reg_we_ex, 1);
        check("norm_valid", valid_ex, 1);
        check("norm_ld", ctrl_l_ex, 1);
        check("norm_rs1", rs1_data_ex, 32'hA5A5_0100);
        check("norm_alu", aluop_ex, 3);
        check("norm_len", stall_len, 0);

        // Single lock
        set_rr(1'b1, 32'h104, 5'd7, 1'b1, 1'b0);
        h_lock = 1'b1;
        #1;
        check("lock1_upstream", {pc_en, if_rr_en, if_rr_flush}, 3'b000);
        step();
        check("lock1_rd", rd_ex, 0);
        check("lock1_valid", valid_ex, 0);
        check("lock1_we", reg_we_ex, 0);
        check("lock1_len", stall_len, 1);
        check("lock1_pc_hold", pc_ex, 32'h100);
        h_lock = 1'b0;
        step();
        check("lock1_rel_rd", rd_ex, 7);
        check("lock1_rel_pc", pc_ex, 32'h104);
        check("lock1_rel_len", stall_len, 0);

        // Double lock: instruction enters EX exactly once
        n_enter = 0;
        set_rr(1'b1, 32'h108, 5'd9, 1'b1, 1'b0);
        h_lock = 1'b1;
        step();
        if (valid_ex && rd_ex == 5'd9) n_enter++;
        check("lock2_len1", stall_len, 1);
        check("lock2_rd1", rd_ex, 0);
        step();
        if (valid_ex && rd_ex == 5'd9) n_enter++;
        check("lock2_len2", stall_len, 2);
        check("lock2_rd2", rd_ex, 0);
        h_lock = 1'b0;
        step();
        if (valid_ex && rd_ex == 5'd9) n_enter++;
        check("lock2_len3", stall_len, 0);
        check("lock2_rd3", rd_ex, 9);
        set_rr(1'b1, 32'h10C, 5'd10, 1'b0, 1'b0);
        step();
        if (valid_ex && rd_ex == 5'd9) n_enter++;
        check("lock2_once", n_enter, 1);
        check("lock2_next_rd", rd_ex, 10);

        // Saturation at 3
        h_lock = 1'b1;
        step(); check("sat_1", stall_len, 1);
        step(); check("sat_2", stall_len, 2);
        step(); check("sat_3", stall_len, 3);
        step(); check("sat_4", stall_len, 3);
        h_lock = 1'b0;
        step(); check("sat_rel", stall_len, 0);

        // Flush beats lock
        h_lock = 1'b1;
        step();
        check("fl_pre_len", stall_len, 1);
        flush_ex = 1'b1;
        #1;
        check("fl_upstream", {pc_en, if_rr_en, if_rr_flush}, 3'b111);
        step();
        check("fl_valid", valid_ex, 0);
        check("fl_rd", rd_ex, 0);
        check("fl_len", stall_len, 0);
        flush_ex = 1'b0;
        step();
        check("fl_run_len", stall_len, 1); // back in RUN, so restarts at 1
        h_lock = 1'b0;

        // Invalid slot forces control to zero
        set_rr(1'b0, 32'h200, 5'd3, 1'b1, 1'b1);
        mem_we_rr = 1'b1; branch_rr = 1'b1; ctrl_r_rr = 1'b1;
        step();
        check("inv_valid", valid_ex, 0);
        check("inv_ctrl", {reg_we_ex, ctrl_l_ex, mem_we_ex, branch_ex, ctrl_r_ex}, 0);
        check("inv_pc", pc_ex, 32'h200);

        // Reset mid-stall
        set_rr(1'b1, 32'h300, 5'd4, 1'b1, 1'b0);
        h_lock = 1'b1;
        step(); step();
        check("rs_pre_len", stall_len, 2);
        rst = 1'b1;
        #1;
        check("rs_upstream", {pc_en, if_rr_en, if_rr_flush}, 3'b111);
        step();
        check("rs_len", stall_len, 0);
        check("rs_pc", pc_ex, 0);
        rst = 1'b0;
        h_lock = 1'b0;

`ifdef RR_EX_PERF_CNT_EN
        // 3 lock cycles, 2 flush cycles, one overlapping a lock
        check("pc_rst_stall", stall_cnt, 0);
        check("pc_rst_flush", flush_cnt, 0);
        h_lock = 1'b1; flush_ex = 1'b0; step();
        h_lock = 1'b1; flush_ex = 1'b0; step();
        h_lock = 1'b1; flush_ex = 1'b1; step();
        h_lock = 1'b0; flush_ex = 1'b1; step();
        h_lock = 1'b0; flush_ex = 1'b0; step();
        check("pc_stall_cnt", stall_cnt, 2);
        check("pc_flush_cnt", flush_cnt, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
